// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART transmitter and receiver.
package uart_pkg;
    localparam int DEFAULT_CLKS_PER_BIT = 10416;
    localparam int DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter with restart; bit_end marks the last cycle of each bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic clk,
    input  logic rst_l,
    input  logic restart,
    output logic bit_end
);
    localparam int W = $clog2(CLKS_PER_BIT);
    logic [W-1:0] cnt;
    assign bit_end = cnt == W'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) cnt <= '0;
        else cnt <= (restart | bit_end) ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 LSB-first UART transmitter with a one-byte holding register.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic [DATA_BITS-1:0] d_out,
    input  logic                 send,
    output logic                 ack,
    output logic                 busy,
    output logic                 tx
);
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] AFTER_DATA = ST_PARITY;
    logic par;
`else
    localparam logic [2:0] AFTER_DATA = ST_STOP;
`endif
    logic [2:0] state, state_next;
    logic [DATA_BITS-1:0] hold, shifter, shifter_next;
    logic hold_full, hold_full_next;
    logic [2:0] bit_cnt;
    logic bit_end, cap, load, last_bit, tx_next;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk(clk),
        .rst_l(rst_l),
        .restart(state_next != state),
        .bit_end(bit_end)
    );

    // ack blocks capture for its own cycle so a late send deassert cannot double-capture
    assign cap = send & ~hold_full & ~ack;
    assign last_bit = bit_cnt == 3'(DATA_BITS - 1);
    assign load = hold_full & ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));
    assign hold_full_next = load ? 1'b0 : cap ? 1'b1 : hold_full;
    assign shifter_next = load ? hold : ((state == ST_DATA) & bit_end) ? shifter >> 1 : shifter;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   state_next = hold_full ? ST_START : ST_IDLE;
            ST_START:  state_next = bit_end ? ST_DATA : ST_START;
            ST_DATA:   state_next = (bit_end & last_bit) ? AFTER_DATA : ST_DATA;
`ifdef UART_TX_PARITY_EN
            ST_PARITY: state_next = bit_end ? ST_STOP : ST_PARITY;
`endif
            ST_STOP:   state_next = bit_end ? (hold_full ? ST_START : ST_IDLE) : ST_STOP;
            default:   state_next = ST_IDLE;
        endcase
    end

    // tx is registered from the next state so the line changes cleanly on the edge
    always_comb begin
        tx_next = LINE_IDLE;
        case (state_next)
            ST_START:  tx_next = ~LINE_IDLE;
            ST_DATA:   tx_next = shifter_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_next = par;
`endif
            default:   tx_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= ST_IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shifter   <= '0;
            bit_cnt   <= '0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            tx        <= LINE_IDLE;
        end else begin
            state     <= state_next;
            hold_full <= hold_full_next;
            shifter   <= shifter_next;
            ack       <= cap;
            busy      <= (state_next != ST_IDLE) | hold_full_next;
            tx        <= tx_next;
            if (cap) hold <= d_out;
            if (load) bit_cnt <= '0;
            else if ((state == ST_DATA) & bit_end) bit_cnt <= bit_cnt + 3'd1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) par <= 1'b0;
        else if (load) par <= ^hold;
    end
`endif
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with a frame-position reference model.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
module tb_uart_tx;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int NB = 11;
    localparam logic [10:0] SEQ_3C = 11'b10001111000;
`else
    localparam bit PAR = 1'b0;
    localparam int NB = 10;
    localparam logic [10:0] SEQ_3C = 11'b01001111000;
`endif
    localparam int FRAME = NB * CPB;

    logic clk = 1'b0;
    logic rst_l = 1'b1;
    logic [7:0] d_out = 8'h00;
    logic send = 1'b0;
    logic ack, busy, tx;
    logic chk_en = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_l(rst_l), .d_out(d_out), .send(send),
        .ack(ack), .busy(busy), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, want, cyc);
        end
    endtask

    // Reference model: position within the current frame plus a one-deep queue.
    int ft, ft_n;
    logic q_full, q_full_n, ack_m, cap_m, ld_m;
    logic [7:0] q_byte, q_byte_n, f_byte, f_byte_n;

    function automatic logic line_at(int t, logic [7:0] b);
        int k;
        k = t / CPB;
        if (t < 0) return 1'b1;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PAR && k == 9) return ^b;
        return 1'b1;
    endfunction

    always_comb begin
        cap_m = send && !q_full && !ack_m;
        ld_m = q_full && (ft < 0 || ft == FRAME - 1);
        ft_n = ld_m ? 0 : (ft < 0 || ft == FRAME - 1) ? -1 : ft + 1;
        f_byte_n = ld_m ? q_byte : f_byte;
        q_full_n = cap_m ? 1'b1 : ld_m ? 1'b0 : q_full;
        q_byte_n = cap_m ? d_out : q_byte;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ft <= -1; q_full <= 1'b0; q_byte <= 8'h00; f_byte <= 8'h00; ack_m <= 1'b0;
        end else begin
            ft <= ft_n; q_full <= q_full_n; q_byte <= q_byte_n; f_byte <= f_byte_n; ack_m <= cap_m;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_l) begin
            check("model_tx", tx, line_at(ft, f_byte));
            check("model_ack", ack, ack_m);
            check("model_busy", busy, (ft >= 0) || q_full);
        end
    end

    // Line decoder: recovers transmitted bytes from mid-bit samples of tx.
    logic [7:0] rx_q[$];
    logic [7:0] dsh = 8'h00;
    int dt = -1;
    always @(negedge clk) begin
        if (!rst_l) dt <= -1;
        else if (dt < 0) begin
            if (tx == 1'b0) dt <= 1;
        end else begin
            if (dt % CPB == 1 && dt / CPB >= 1 && dt / CPB <= 8) dsh[dt/CPB-1] <= tx;
            if (dt == FRAME - 1) begin
                rx_q.push_back(dsh);
                dt <= -1;
            end else dt <= dt + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b, output int ts, output int ta);
        int n;
        n = 0;
        @(negedge clk);
        d_out = b;
        send = 1'b1;
        ts = cyc;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 400);
        ta = cyc;
        check("ack_seen", ack, 1);
        send = 1'b0;
    endtask

    task automatic wait_tx_low(output int t);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        check("tx_start_seen", tx, 0);
    endtask

    task automatic wait_idle(output int t);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        check("busy_cleared", busy, 0);
    endtask

    task automatic expect_rx(input int idx, input logic [7:0] b);
        check("rx_count", rx_q.size() > idx, 1);
        if (rx_q.size() > idx) check("rx_byte", rx_q[idx], b);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic parity_case(input logic [7:0] b, input logic want);
        int ts, ta, t0, t1;
        send_byte(b, ts, ta);
        wait_tx_low(t0);
        while (cyc < t0 + 9 * CPB + 1) @(negedge clk);
        check("parity_bit", tx, want);
        wait_idle(t1);
        check("parity_frame_len", t1 - t0, 44);
    endtask
`endif

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    initial begin : main
        int ts, ta, ta1, ta2, ta3, t0, t1, base;
        logic [10:0] seq;
        seq = SEQ_3C;
        #2 rst_l = 1'b0;
        #1;
        check("rst_tx", tx, 1);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_after_reset", {tx, busy, ack}, 3'b100);
        end

        base = rx_q.size();
        send_byte(8'h3C, ts, ta);
        check("ack_latency", ta - ts, 1);
        @(negedge clk);
        check("ack_one_cycle", ack, 0);
        wait_tx_low(t0);
        check("tx_fall_latency", t0 - ts, 2);
        for (int i = 0; i < FRAME; i++) begin
            if (i % CPB == 1) check($sformatf("bit%0d_3c", i / CPB), tx, seq[i/CPB]);
            @(negedge clk);
        end
        wait_idle(t1);
        check("busy_fall_3c", t1 - t0, FRAME);
        expect_rx(base, 8'h3C);

        base = rx_q.size();
        send_byte(8'h55, ts, ta);
        wait_tx_low(t0);
        repeat (6) @(negedge clk);
        send_byte(8'hA3, ts, ta2);
        check("b2b_ack_in_data", (ta2 - t0 >= CPB) && (ta2 - t0 < 9 * CPB), 1);
        while (cyc < t0 + FRAME - 1) @(negedge clk);
        check("b2b_stop_last", tx, 1);
        @(negedge clk);
        check("b2b_second_start", tx, 0);
        wait_idle(t1);
        check("b2b_contiguous", t1 - t0, 2 * FRAME);
        expect_rx(base, 8'h55);
        expect_rx(base + 1, 8'hA3);

        base = rx_q.size();
        send_byte(8'h11, ts, ta1);
        send_byte(8'h22, ts, ta2);
        check("hold_second_ack", ta2 - ta1, 2);
        send_byte(8'h33, ts, ta3);
        check("hold_off_ack", ta3 - ta1, FRAME + 2);
        wait_idle(t1);
        check("hold_count", rx_q.size() - base, 3);
        expect_rx(base, 8'h11);
        expect_rx(base + 1, 8'h22);
        expect_rx(base + 2, 8'h33);

        base = rx_q.size();
        send_byte(8'hF0, ts, ta);
        wait_tx_low(t0);
        while (cyc < t0 + 17) @(negedge clk);
        #2 rst_l = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_ack", ack, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_l = 1'b1;
        send_byte(8'h81, ts, ta);
        wait_tx_low(t0);
        wait_idle(t1);
        check("post_rst_frame_len", t1 - t0, FRAME);
        check("post_rst_count", rx_q.size() - base, 1);
        expect_rx(base, 8'h81);

`ifdef UART_TX_PARITY_EN
        parity_case(8'h07, 1'b1);
        parity_case(8'h03, 1'b0);
`endif

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter, 8N1, LSB first. It is the transmit-side counterpart of the existing uart_rx.
- Lets the design send bytes back to the host (for example note echo or status) over the same serial link.
- A one-byte holding register sits in front of the shift register, so the next byte can be queued while the current frame is on the wire. This gives gap-free back-to-back frames.

Parameters:
- CLKS_PER_BIT, 10416, clock cycles per bit (100 MHz / 9600 baud). Must be at least 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_l  input  1  asynchronous active-low reset.
- d_out  input  8  byte to transmit; must be stable while send is high.
- send  input  1  level request from the host: "d_out is valid".
- ack  output  1  one-cycle pulse: d_out has been captured into the holding register.
- busy  output  1  high while a frame is in flight or a byte is queued.
- tx  output  1  serial line; idle high.

Behaviour:
- Reset (rst_l low, acts immediately, independent of clk):
  - tx=1, ack=0, busy=0.
  - Holding register empty, FSM in IDLE, bit counter and baud counter cleared.
  - Reset mid-frame aborts the frame and drives the line high at once. No partial byte is retained.
- Host handshake:
  - Capture occurs at the edge where send=1, hold_full=0 and ack=0.
  - On capture: hold <= d_out, hold_full <= 1, ack=1 for exactly the next cycle.
  - The host deasserts send on the cycle after seeing ack. send is ignored while ack=1, so a late deassert never double-captures.
  - While hold_full=1, send is held off: no ack is issued and hold is not overwritten.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
  - Each bit state lasts exactly CLKS_PER_BIT cycles, timed by a baud counter that restarts on every state entry.
  - IDLE: tx=1. If hold_full, then on the next edge: shifter <= hold, hold_full <= 0, go to START.
  - START: tx=0.
  - DATA: tx = shifter[0]. Shift right at each bit end; 3-bit counter, leave after bit 7.
  - STOP: tx=1. At the end of the stop bit:
    - hold_full=1: load the shifter and go directly to START (zero idle gap);
    - hold_full=0: go to IDLE.
- Latency:
  - With the FSM in IDLE, capture occurs at edge E0, the shifter loads at E1, and tx goes low after E1.
  - tx therefore falls 2 cycles after send is first sampled.
- Frame length: 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
- Simultaneous events:
  - A capture in the same cycle the STOP bit ends is not seen by that cycle's load decision. That byte starts from IDLE one cycle later.
  - A load frees the holding register; a new capture may occur on the following edge.
- busy = (state != IDLE) | hold_full. busy falls the cycle after the last stop-bit cycle when nothing is queued.
- All outputs are registered; tx is glitch-free.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx = even parity, i.e. XOR of the 8 data bits, for CLKS_PER_BIT cycles. Frame becomes 11 bits. uart_rx must be built with the matching parity setting.
- Undefined: no PARITY state and no parity logic; plain 8N1.

Decomposition:
- Package uart_pkg holds:
  - the state encoding (IDLE/START/DATA/PARITY/STOP);
  - DEFAULT_CLKS_PER_BIT;
  - DATA_BITS=8;
  - the idle/stop line level constant.
  - uart_rx shares the package.
- Natural sub-module uart_baud_gen: a counter with restart input and a bit_end pulse every CLKS_PER_BIT cycles. uart_rx can reuse it for its half-bit sampling.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset:
  - rst_l low → tx=1, ack=0, busy=0 immediately without a clock edge.
  - Release → outputs stay idle with send=0 for 100 cycles.
- Single byte 0x3C:
  - ack pulses for 1 cycle; tx falls 2 cycles after send is sampled.
  - tx then carries 0,0,0,1,1,1,1,0,0,1 (start, LSB-first data, stop), each bit 4 cycles.
  - busy falls 40 cycles after tx falls.
- Back-to-back 0x55 then 0xA3:
  - The second send is acked during the first frame's DATA bits.
  - The second start bit begins the cycle after the first stop bit ends; 80 contiguous non-idle frame cycles.
- Hold-off with send held high:
  - Queue 0x11 and 0x22 while the 0x11 frame is shifting.
  - Hold 0x33 on send: no ack while hold_full.
  - ack arrives only when 0x22 loads; the wire shows 0x11, 0x22, 0x33 in order, with none lost or overwritten.
- Reset mid-frame during data bit 3 of 0xF0:
  - tx=1 and busy=0 immediately.
  - A subsequent send of 0x81 produces a clean full frame.
- UART_TX_PARITY_EN defined:
  - 0x07 → parity bit 1.
  - 0x03 → parity bit 0.
  - Frame is 44 cycles.
